cpu_bus_responder: RTL and testbench
====================================

# cpu_bus_responder

Memory-side responder for the 6-bit tiny-CPU external bus. It serves program words to the CPU's address/data pins from a 64-entry writable store. It loads that store from a valid/ready loader stream while holding the CPU in reset. It also captures each CPU output strobe into a small FIFO for the host to drain. It sits between the CPU core pins (address out, data in, output strobe) and the test/host logic.

## Interface
- FIFO_DEPTH, 4: capture FIFO entries; power of two, 2..16.
- LOAD_LEN, 64: words accepted per load sequence, 1..64.
- FILL_WORD, 6'd0: reset value of every store entry.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cpu_addr  in  6  CPU address (CPU io_out[5:0]); also the output value during a strobe.
- cpu_strobe  in  1  CPU output strobe (CPU io_out[7]).
- cpu_data  out  6  registered read data to CPU (CPU io_in[7:2]).
- cpu_rst  out  1  active-high CPU reset request.
- ld_start  in  1  single-cycle pulse; begins a load sequence.
- ld_valid  in  1  loader word valid.
- ld_data  in  6  loader word.
- ld_ready  out  1  responder accepts a word this cycle.
- ld_busy  out  1  load sequence in progress.
- cap_valid  out  1  capture FIFO non-empty.
- cap_data  out  6  FIFO head, first-word-fall-through.
- cap_ready  in  1  host pops the head when cap_valid=1.
- cap_overflow  out  1  sticky: a capture was dropped.

## Operation
- FSM states: RELEASE, RUN, LOAD.
  - RELEASE: cpu_rst=1 for exactly one cycle, then RUN.
  - RUN: cpu_rst=0; captures enabled.
  - LOAD: cpu_rst=1, ld_busy=1, ld_ready=1.
- ld_start in any state → LOAD next cycle. Write pointer is cleared to 0, the capture FIFO is flushed, and cap_overflow is cleared. ld_start during LOAD restarts at pointer 0.
- In LOAD, each ld_valid&ld_ready cycle writes ld_data to mem[ptr] and increments ptr.
  - The write at ptr==LOAD_LEN-1 moves the FSM to RELEASE.
  - Entries ≥LOAD_LEN keep their previous contents.
- ld_start and ld_valid in the same cycle: ld_start wins and the word is not written.
- Read path: every cycle in all states, cpu_data <= mem[cpu_addr].
  - A same-cycle write to the same address returns the old value.
  - The new value appears on cpu_data one cycle later.
- Capture: strobe_q registers cpu_strobe. A rising edge (cpu_strobe & ~strobe_q) in RUN pushes cpu_addr. Edges in LOAD or RELEASE are ignored.
- FIFO full with push and no pop: the word is dropped and cap_overflow sets. Full with push and pop in the same cycle: both succeed and the count is unchanged. Empty with push: cap_valid rises next cycle; the same-cycle pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide.

## Timing
- Reset values: state RELEASE, cpu_rst=1, cpu_data=FILL_WORD, all mem=FILL_WORD, ld_ready=0, ld_busy=0, cap_valid=0, cap_data=FILL_WORD, cap_overflow=0, strobe_q=0, ptr=0.
- First rising edge after rst_n deassert: RELEASE→RUN, so cpu_rst falls after that edge.
- Read latency: 1 cycle from cpu_addr to cpu_data.
- Load: ld_start at edge N gives ld_ready=1 from N+1. The last word accepted at edge M gives RELEASE during M+1 and RUN from M+2.
- Capture latency: strobe edge sampled at edge N gives cap_valid=1 after N+1.
- rst_n asserted mid-load aborts immediately. Store contents return to FILL_WORD; partial loads are not preserved.

## Test plan
- Reset: hold rst_n=0, then release → cpu_rst=1 for one cycle; all outputs at their reset values; cpu_data=0 for any address.
- Load and run: ld_start, then stream 12 words {1,2,16,6,0,7,63,4,1,3,5,7} with LOAD_LEN=12 → ld_ready drops after the 12th word, cpu_rst falls 2 cycles later, and cpu_addr=6 reads back 63 one cycle later.
- Loader backpressure: toggle ld_valid randomly → only accepted words are written; ld_start mid-load at ptr=5 → restart at 0 with no writes from the previous partial sequence beyond what was accepted.
- Capture: in RUN, pulse cpu_strobe three times with cpu_addr=9, 18, 27 → FIFO pops 9, 18, 27 in order; a strobe held high for 4 cycles pushes once.
- Overflow: with FIFO_DEPTH=4 and cap_ready=0, send 5 strobes → 4 entries held and cap_overflow=1. A push with a pop while full keeps count=4 with no new overflow. ld_start clears the flag and empties the FIFO.
- Async reset during LOAD at ptr=7 → cpu_rst=1 immediately, mem reads FILL_WORD, FSM in RELEASE.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the tiny-CPU bus: 64-word program store with a
// valid/ready loader, CPU reset sequencing, and an output-strobe capture FIFO.
module cpu_bus_responder #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          LOAD_LEN   = 64,
    parameter logic [5:0]  FILL_WORD  = 6'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  cpu_addr,
    input  logic        cpu_strobe,
    output logic [5:0]  cpu_data,
    output logic        cpu_rst,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [5:0]  ld_data,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        cap_valid,
    output logic [5:0]  cap_data,
    input  logic        cap_ready,
    output logic        cap_overflow,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_RELEASE = 2'd0,
        S_RUN     = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    localparam int         PW   = $clog2(FIFO_DEPTH);
    localparam int         CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [5:0] LAST = 6'(LOAD_LEN - 1);

    // Handshake: a loader word transfers on any rising clk edge where
    // ld_valid && ld_ready; ld_start in the same cycle takes priority.
    state_t          r_state, w_next;
    logic [5:0]      r_mem [64];
    logic [5:0]      r_ptr;
    logic [5:0]      r_cpu_data;
    logic            r_strobe_q;
    logic [5:0]      r_fifo [FIFO_DEPTH];
    logic [PW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count;
    logic            r_ovf;

    logic w_wr_en, w_push, w_pop, w_full, w_push_ok;

    assign w_wr_en   = (r_state == S_LOAD) && ld_valid && !ld_start;
    assign w_push    = cpu_strobe && !r_strobe_q && (r_state == S_RUN);
    assign w_pop     = cap_ready && (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RELEASE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        cpu_rst  = 1'b1;
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        case (r_state)
            S_RELEASE: w_next = S_RUN;
            S_RUN:     cpu_rst = 1'b0;
            S_LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (w_wr_en && r_ptr == LAST) w_next = S_RELEASE;
            end
            default:   w_next = S_RELEASE;
        endcase
        if (ld_start) w_next = S_LOAD;
    end

    // Reading before writing gives old-data-on-collision for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) r_mem[i] <= FILL_WORD;
            r_cpu_data <= FILL_WORD;
            r_ptr      <= 6'd0;
            r_strobe_q <= 1'b0;
        end else begin
            r_cpu_data <= r_mem[cpu_addr];
            r_strobe_q <= cpu_strobe;
            if (w_wr_en) r_mem[r_ptr] <= ld_data;
            if (ld_start)     r_ptr <= 6'd0;
            else if (w_wr_en) r_ptr <= r_ptr + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= FILL_WORD;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (ld_start) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pop) r_rd <= r_rd + PW'(1);
            if (w_push_ok) begin
                r_fifo[r_wr] <= cpu_addr;
                r_wr         <= r_wr + PW'(1);
            end
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
        end
    end

    assign cpu_data     = r_cpu_data;
    assign cap_valid    = (r_count != '0);
    assign cap_data     = r_fifo[r_rd];
    assign cap_overflow = r_ovf;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: a behavioural model (array store,
// queue FIFO, load/release flags) checked every cycle, plus literal checks.
module tb_cpu_bus_responder;
    localparam int         DEPTH = 4;
    localparam int         LEN   = 12;
    localparam logic [5:0] FILL  = 6'd0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] cpu_addr;
    logic       cpu_strobe;
    logic [5:0] cpu_data;
    logic       cpu_rst;
    logic       ld_start, ld_valid;
    logic [5:0] ld_data;
    logic       ld_ready, ld_busy;
    logic       cap_valid;
    logic [5:0] cap_data;
    logic       cap_ready;
    logic       cap_overflow;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_bus_responder #(.FIFO_DEPTH(DEPTH), .LOAD_LEN(LEN), .FILL_WORD(FILL)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_strobe(cpu_strobe),
        .cpu_data(cpu_data), .cpu_rst(cpu_rst), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .cap_valid(cap_valid), .cap_data(cap_data),
        .cap_ready(cap_ready), .cap_overflow(cap_overflow), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [5:0] m_mem [64];
    logic [5:0] exp_q [$];
    logic [5:0] m_data;
    bit         m_load, m_rel, m_ovf, m_sq;
    int         m_ptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_mem[i] = FILL;
            exp_q.delete();
            m_data = FILL;
            m_load = 0; m_rel = 1; m_ovf = 0; m_sq = 0; m_ptr = 0;
        end else begin
            bit in_run, rise, pop, push;
            in_run = !m_load && !m_rel;
            rise   = cpu_strobe && !m_sq;
            m_sq   = cpu_strobe;
            m_data = m_mem[cpu_addr];
            if (ld_start) begin
                m_load = 1; m_rel = 0; m_ptr = 0; m_ovf = 0;
                exp_q.delete();
            end else begin
                pop  = cap_ready && exp_q.size() > 0;
                push = rise && in_run;
                if (push && exp_q.size() == DEPTH && !pop) m_ovf = 1;
                else begin
                    if (pop)  void'(exp_q.pop_front());
                    if (push) exp_q.push_back(cpu_addr);
                end
                if (m_load && ld_valid) begin
                    m_mem[m_ptr] = ld_data;
                    if (m_ptr == LEN - 1) begin m_load = 0; m_rel = 1; end
                    m_ptr++;
                end else if (m_rel) m_rel = 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("cpu_data", cpu_data, m_data);
            cmp("cpu_rst", cpu_rst, int'(m_load || m_rel));
            cmp("ld_ready", ld_ready, int'(m_load));
            cmp("ld_busy", ld_busy, int'(m_load));
            cmp("cap_valid", cap_valid, int'(exp_q.size() > 0));
            cmp("cap_overflow", cap_overflow, int'(m_ovf));
            if (exp_q.size() > 0) cmp("cap_data", cap_data, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    logic [5:0] wtab [LEN];

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic load_seq(input int n, input bit bp);
        int acc = 0;
        int guard = 0;
        ld_start = 1; step(); ld_start = 0;
        while (acc < n && guard < 300) begin
            ld_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            ld_data  = wtab[acc];
            if (ld_valid) acc++;
            step();
            guard++;
        end
        ld_valid = 0;
        if (guard >= 300) cmp("load_timeout", guard, 0);
    endtask

    task automatic strobe_pulse(input logic [5:0] a, input int hold);
        cpu_addr = a; cpu_strobe = 1;
        repeat (hold) step();
        cpu_strobe = 0; step();
    endtask

    task automatic sweep();
        for (int a = 0; a < 64; a++) begin cpu_addr = 6'(a); step(); end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] pat [LEN];
        pat = '{6'd1, 6'd2, 6'd16, 6'd6, 6'd0, 6'd7, 6'd63, 6'd4, 6'd1, 6'd3, 6'd5, 6'd7};
        rst_n = 0; cpu_addr = 6'd5; cpu_strobe = 0; ld_start = 0; ld_valid = 0;
        ld_data = 0; cap_ready = 0;
        repeat (3) step();
        cmp("rst_cpu_rst", cpu_rst, 1);
        cmp("rst_cpu_data", cpu_data, 0);
        cmp("rst_ld_ready", ld_ready, 0);
        cmp("rst_cap_valid", cap_valid, 0);
        cmp("rst_cap_data", cap_data, 0);
        cmp("rst_overflow", cap_overflow, 0);
        rst_n = 1;
        @(negedge clk); cmp("release_cpu_rst", cpu_rst, 1);
        step();
        @(negedge clk); cmp("run_cpu_rst", cpu_rst, 0);
        sweep();

        // load the 12-word pattern
        wtab = pat;
        cpu_addr = 6'd6;
        load_seq(LEN, 0);
        @(negedge clk);
        cmp("last_ld_ready", ld_ready, 0);
        cmp("last_cpu_rst", cpu_rst, 1);
        step();
        @(negedge clk); cmp("load_cpu_rst_fall", cpu_rst, 0);
        cpu_addr = 6'd6; step();
        @(negedge clk); cmp("read_addr6", cpu_data, 63);
        cpu_addr = 6'd2; step();
        @(negedge clk); cmp("read_addr2", cpu_data, 16);
        sweep();

        // backpressure: partial load to ptr 5, restart with ld_start+ld_valid
        begin
            int acc = 0;
            int guard = 0;
            ld_start = 1; step(); ld_start = 0;
            while (acc < 5 && guard < 200) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                ld_data  = 6'($urandom_range(32, 63));
                if (ld_valid) acc++;
                step(); guard++;
            end
            ld_start = 1; ld_valid = 1; ld_data = 6'd11; step();
            ld_start = 0; ld_valid = 0;
        end
        for (int i = 0; i < LEN; i++) wtab[i] = 6'($urandom_range(0, 63));
        ld_valid = 0;
        // continue the already-started sequence with backpressure
        begin
            int acc = 0;
            int guard = 0;
            while (acc < LEN && guard < 300) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                ld_data  = wtab[acc];
                if (ld_valid) acc++;
                step(); guard++;
            end
            ld_valid = 0;
            if (guard >= 300) cmp("bp_timeout", guard, 0);
        end
        step(); step();
        cpu_addr = 6'd0; step();
        @(negedge clk); cmp("bp_addr0", cpu_data, wtab[0]);
        sweep();

        // capture order and held strobe
        strobe_pulse(6'd9, 1);
        strobe_pulse(6'd18, 1);
        strobe_pulse(6'd27, 1);
        strobe_pulse(6'd40, 4);
        cap_ready = 1;
        @(negedge clk); cmp("pop0", cap_data, 9);
        step(); @(negedge clk); cmp("pop1", cap_data, 18);
        step(); @(negedge clk); cmp("pop2", cap_data, 27);
        step(); @(negedge clk); cmp("pop3", cap_data, 40);
        step(); @(negedge clk); cmp("drained", cap_valid, 0);
        cap_ready = 0;

        // overflow, then full push+pop, then clear with ld_start
        for (int i = 1; i <= 5; i++) strobe_pulse(6'(i), 1);
        @(negedge clk);
        cmp("ovf_set", cap_overflow, 1);
        cmp("ovf_head", cap_data, 1);
        cap_ready = 1; cpu_addr = 6'd6; cpu_strobe = 1; step();
        cap_ready = 0; cpu_strobe = 0; step();
        @(negedge clk); cmp("full_pushpop_head", cap_data, 2);
        wtab = pat;
        ld_start = 1; step(); ld_start = 0;
        @(negedge clk);
        cmp("clr_ovf", cap_overflow, 0);
        cmp("clr_valid", cap_valid, 0);
        load_seq(LEN, 0);
        step(); step();

        // async reset mid-load at ptr 7
        for (int i = 0; i < LEN; i++) wtab[i] = 6'($urandom_range(1, 63));
        cpu_addr = 6'd3;
        load_seq(7, 0);
        rst_n = 0; #1;
        cmp("arst_cpu_rst", cpu_rst, 1);
        cmp("arst_cpu_data", cpu_data, 0);
        cmp("arst_ld_busy", ld_busy, 0);
        cmp("arst_state", dbg_state, 0);
        step(); step();
        rst_n = 1;
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
